exec_clock_counter_bank: RTL and testbench
==========================================

EXEC_CLOCK_COUNTER_BANK -- requirements
Module: exec_clock_counter_bank

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, meaning counter width in bits; legal range 8..16.
REQ-002 SHALL provide parameter NCH, default 4, meaning number of independent counter channels; legal range 1..4.
REQ-003 SHALL provide parameter SAT, default 0, meaning overflow mode: 0 = wrap to zero, 1 = saturate at all-ones.
REQ-004 SHALL provide parameter RES_BASE, default 8'h0E, meaning first result-bus address of the register map.
REQ-005 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_N  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port cmd_valid  input  1  command strobe, sampled at the rising edge.
REQ-008 SHALL have port cmd_op  input  2  command code: 0 CLEAR, 1 START, 2 STOP, 3 SNAP.
REQ-009 SHALL have port cmd_all  input  1  when 1, the command applies to every channel and cmd_ch is ignored.
REQ-010 SHALL have port cmd_ch  input  2  target channel index.
REQ-011 SHALL have port resad  input  8  result-bus read address.
REQ-012 SHALL have port resdt  output  8  result-bus read data, combinational from resad and registered state.
REQ-013 SHALL have port running  output  NCH  per-channel run flag.
REQ-014 SHALL have port ovf  output  NCH  per-channel sticky overflow flag.

Function
REQ-015 Each channel SHALL hold count[CNT_W-1:0], run, ovf and snap[CNT_W-1:0] registers.
REQ-016 If run=1 before an edge, count SHALL increment by 1 at that edge unless CLEAR targets the channel at that edge.
REQ-017 START SHALL set run at the edge it is sampled; the first increment SHALL occur at the following edge.
REQ-018 STOP SHALL clear run at the edge it is sampled; that edge's increment, if any, SHALL still occur.
REQ-019 STOP SHALL load snap with the count value after that edge's increment.
REQ-020 CLEAR SHALL set count to 0 and ovf to 0 and SHALL leave run and snap unchanged; CLEAR wins over a same-edge increment.
REQ-021 SNAP SHALL load snap with the count value after that edge's increment, without changing run.
REQ-022 A command with cmd_all=0 and cmd_ch>=NCH SHALL have no effect.
REQ-023 START on a running channel and STOP on a stopped channel SHALL leave run unchanged; STOP on a stopped channel SHALL still load snap.
REQ-024 With SAT=0, an increment from all-ones SHALL yield 0 and set ovf=1.
REQ-025 With SAT=1, an increment at all-ones SHALL hold all-ones and set ovf=1.
REQ-026 ovf SHALL remain 1 until CLEAR or reset.
REQ-027 resdt SHALL return {zero-extended snap[CNT_W-1:8]} at address RES_BASE+2*ch, for ch < NCH.
REQ-028 resdt SHALL return snap[7:0] at address RES_BASE+2*ch+1, for ch < NCH.
REQ-029 resdt SHALL return {running zero-extended to 4 bits, ovf zero-extended to 4 bits} at address RES_BASE+2*NCH.
REQ-030 resdt SHALL be 8'h00 for all unmapped addresses; it SHALL never be driven to Z.
REQ-031 running and ovf outputs SHALL equal the internal registers directly, with no extra latency.

Reset
REQ-032 With reset_N=0 at a rising edge, every count, snap, run and ovf SHALL become 0.
REQ-033 Reset SHALL dominate any command or increment on the same edge, including mid-run; after reset, resdt SHALL read 8'h00 at every address.

Verification
REQ-034 Reset for 1 edge with cmd_valid=1 START -> running=0, ovf=0, resdt=00 at 0E..16.
REQ-035 START ch0 at edge 0, STOP ch0 at edge 10 -> running[0]=0, resdt[0E]=00, resdt[0F]=0A.
REQ-036 CNT_W=8, SAT=0: START ch1 and run 256 edges, then SNAP ch1 -> resdt[11]=00, ovf[1]=1; with SAT=1 -> resdt[11]=FF, ovf[1]=1.
REQ-037 ch2 running with count 5, CLEAR ch2 -> next edge count 1; SNAP then reads 01; ovf[2]=0; running[2] stays 1.
REQ-038 cmd_all START, then STOP ch1 after 3 edges -> status byte at 16 = 8'hD0; resdt[10]=00 and resdt[11]=03.
REQ-039 ch3 running, reset_N=0 for one edge mid-run together with SNAP -> all registers 0, and the count does not resume after reset release.

Source files
------------

// File: rtl/exec_clock_counter_bank.sv
// Bank of NCH independent cycle counters with start/stop/clear/snapshot commands
// and a byte-wide combinational read bus exposing snapshots and status flags.
module exec_clock_counter_bank #(
    parameter int          CNT_W    = 16,
    parameter int          NCH      = 4,
    parameter bit          SAT      = 1'b0,
    parameter logic [7:0]  RES_BASE = 8'h0E
) (
    input  logic           clock,
    input  logic           reset_N,
    input  logic           cmd_valid,
    input  logic [1:0]     cmd_op,
    input  logic           cmd_all,
    input  logic [1:0]     cmd_ch,
    input  logic [7:0]     resad,
    output logic [7:0]     resdt,
    output logic [NCH-1:0] running,
    output logic [NCH-1:0] ovf
);

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_START = 2'd1,
        OP_STOP  = 2'd2,
        OP_SNAP  = 2'd3
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       STATUS_AD = 8'(int'(RES_BASE) + 2 * NCH);

    op_e              op;
    logic [CNT_W-1:0] count_q   [NCH];
    logic [CNT_W-1:0] snap_q    [NCH];
    logic [CNT_W-1:0] count_inc [NCH];
    logic [15:0]      snap_ext  [NCH];
    logic [NCH-1:0]   run_q;
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   hit;
    logic [NCH-1:0]   wrap;

    assign op = op_e'(cmd_op);

    // Per-channel targeting and the post-increment count every command observes.
    // A channel index at or above NCH never matches, so such commands are dropped.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            hit[i]       = cmd_valid && (cmd_all || (int'(cmd_ch) == i));
            count_inc[i] = count_q[i];
            wrap[i]      = 1'b0;
            if (run_q[i]) begin
                if (count_q[i] == CNT_MAX) begin
                    wrap[i]      = 1'b1;
                    count_inc[i] = SAT ? CNT_MAX : '0;
                end else begin
                    count_inc[i] = count_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous, so it is just the highest-priority branch of the clocked block.
        if (!reset_N) begin
            for (int i = 0; i < NCH; i++) begin
                count_q[i] <= '0;
                snap_q[i]  <= '0;
            end
            run_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // NOTE: non-blocking assignments; a later assignment in this block overrides an earlier one, which is how CLEAR beats the increment.
                count_q[i] <= count_inc[i];
                if (wrap[i]) ovf_q[i] <= 1'b1;
                if (hit[i]) begin
                    case (op)
                        OP_CLEAR: begin
                            count_q[i] <= '0;
                            ovf_q[i]   <= 1'b0;
                        end
                        OP_START: run_q[i] <= 1'b1;
                        OP_STOP: begin
                            run_q[i]  <= 1'b0;
                            snap_q[i] <= count_inc[i];
                        end
                        OP_SNAP: snap_q[i] <= count_inc[i];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) snap_ext[i] = 16'(snap_q[i]);
    end

    // Each channel owns a high/low byte pair starting at RES_BASE; status follows the last pair.
    always_comb begin
        resdt = 8'h00;
        for (int i = 0; i < NCH; i++) begin
            if (resad == 8'(int'(RES_BASE) + 2 * i))     resdt = snap_ext[i][15:8];
            if (resad == 8'(int'(RES_BASE) + 2 * i + 1)) resdt = snap_ext[i][7:0];
        end
        if (resad == STATUS_AD) resdt = {4'(run_q), 4'(ovf_q)};
    end

    assign running = run_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_exec_clock_counter_bank.sv
// Drives three differently-parameterised counter banks with shared directed and random
// commands and compares every output against an arithmetic reference model.
module tb_exec_clock_counter_bank;

    localparam int OP_CLEAR = 0;
    localparam int OP_START = 1;
    localparam int OP_STOP  = 2;
    localparam int OP_SNAP  = 3;
    localparam int BASE     = 'h0E;

    logic       clock = 1'b0;
    logic       reset_N;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_all;
    logic [1:0] cmd_ch;
    logic [7:0] resad;
    logic [7:0] resdt_a, resdt_b, resdt_c;
    logic [3:0] running_a, ovf_a, running_b, ovf_b;
    logic [2:0] running_c, ovf_c;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance parameters: a = 16-bit wrap x4, b = 8-bit wrap x4, c = 8-bit saturate x3.
    int m_w   [3] = '{16, 8, 8};
    int m_sat [3] = '{0, 0, 1};
    int m_nch [3] = '{4, 4, 3};

    int unsigned m_cnt  [3][4];
    int unsigned m_snap [3][4];
    bit          m_run  [3][4];
    bit          m_ovf  [3][4];

    exec_clock_counter_bank #(.CNT_W(16), .NCH(4), .SAT(1'b0)) u_dut_a (
        .clock(clock), .reset_N(reset_N), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_all(cmd_all), .cmd_ch(cmd_ch), .resad(resad), .resdt(resdt_a),
        .running(running_a), .ovf(ovf_a)
    );

    exec_clock_counter_bank #(.CNT_W(8), .NCH(4), .SAT(1'b0)) u_dut_b (
        .clock(clock), .reset_N(reset_N), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_all(cmd_all), .cmd_ch(cmd_ch), .resad(resad), .resdt(resdt_b),
        .running(running_b), .ovf(ovf_b)
    );

    exec_clock_counter_bank #(.CNT_W(8), .NCH(3), .SAT(1'b1)) u_dut_c (
        .clock(clock), .reset_N(reset_N), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_all(cmd_all), .cmd_ch(cmd_ch), .resad(resad), .resdt(resdt_c),
        .running(running_c), .ovf(ovf_c)
    );

    always #50 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference model, applied from the command as sampled.
    task automatic model_edge(input bit rst, input bit valid, input int op, input bit all, input int ch);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < m_nch[k]; i++) begin
                int unsigned mx, nxt;
                bit          novf;
                if (rst) begin
                    m_cnt[k][i] = 0; m_snap[k][i] = 0; m_run[k][i] = 0; m_ovf[k][i] = 0;
                    continue;
                end
                mx   = (32'd1 << m_w[k]) - 1;
                nxt  = m_cnt[k][i];
                novf = m_ovf[k][i];
                if (m_run[k][i]) begin
                    if (nxt == mx) begin
                        novf = 1'b1;
                        nxt  = (m_sat[k] != 0) ? mx : 0;
                    end else begin
                        nxt = nxt + 1;
                    end
                end
                if (valid && (all || ch == i)) begin
                    case (op)
                        OP_CLEAR: begin nxt = 0; novf = 1'b0; end
                        OP_START: m_run[k][i] = 1'b1;
                        OP_STOP:  begin m_run[k][i] = 1'b0; m_snap[k][i] = nxt; end
                        default:  m_snap[k][i] = nxt;
                    endcase
                end
                m_cnt[k][i] = nxt;
                m_ovf[k][i] = novf;
            end
        end
    endtask

    function automatic int exp_bits(int k, bit sel_ovf);
        int r = 0;
        for (int i = 0; i < m_nch[k]; i++)
            if (sel_ovf ? m_ovf[k][i] : m_run[k][i]) r |= (1 << i);
        return r;
    endfunction

    function automatic int exp_rd(int k, int a);
        int r = 0;
        for (int i = 0; i < m_nch[k]; i++) begin
            if (a == BASE + 2 * i)     r = (m_snap[k][i] >> 8) & 'hFF;
            if (a == BASE + 2 * i + 1) r = m_snap[k][i] & 'hFF;
        end
        if (a == BASE + 2 * m_nch[k]) r = (exp_bits(k, 1'b0) << 4) | exp_bits(k, 1'b1);
        return r;
    endfunction

    function automatic logic [31:0] got_rd(int k);
        case (k)
            0:       return 32'(resdt_a);
            1:       return 32'(resdt_b);
            default: return 32'(resdt_c);
        endcase
    endfunction

    function automatic logic [31:0] got_bits(int k, bit sel_ovf);
        case (k)
            0:       return sel_ovf ? 32'(ovf_a) : 32'(running_a);
            1:       return sel_ovf ? 32'(ovf_b) : 32'(running_b);
            default: return sel_ovf ? 32'(ovf_c) : 32'(running_c);
        endcase
    endfunction

    task automatic step(input bit rst, input bit valid, input int op, input bit all, input int ch);
        @(negedge clock);
        reset_N   = !rst;
        cmd_valid = valid;
        cmd_op    = 2'(op);
        cmd_all   = all;
        cmd_ch    = 2'(ch);
        @(posedge clock);
        model_edge(rst, valid, op, all, ch);
        #1;
        reset_N   = 1'b1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic rd(input int a);
        resad = 8'(a);
        #1;
    endtask

    task automatic check_status(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_running"}, got_bits(k, 1'b0), 32'(exp_bits(k, 1'b0)));
            check({tag, "_ovf"},     got_bits(k, 1'b1), 32'(exp_bits(k, 1'b1)));
        end
    endtask

    task automatic sweep(input string tag);
        check_status(tag);
        for (int a = 'h0C; a <= 'h18; a++) begin
            rd(a);
            for (int k = 0; k < 3; k++) check({tag, "_resdt"}, got_rd(k), 32'(exp_rd(k, a)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_running_a"}, 32'(running_a), 0);
        check({tag, "_ovf_a"},     32'(ovf_a), 0);
        check({tag, "_running_c"}, 32'(running_c), 0);
        for (int a = 'h0E; a <= 'h16; a++) begin
            rd(a);
            check({tag, "_resdt_a"}, 32'(resdt_a), 0);
            check({tag, "_resdt_b"}, 32'(resdt_b), 0);
            check({tag, "_resdt_c"}, 32'(resdt_c), 0);
        end
    endtask

    initial begin
        reset_N   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'(OP_START);
        cmd_all   = 1'b1;
        cmd_ch    = 2'd0;
        resad     = 8'h00;

        // Reset while a START-all is presented.
        step(1'b1, 1'b1, OP_START, 1'b1, 0);
        check_all_zero("reset");
        sweep("reset");

        // START ch0, STOP ten edges later.
        step(1'b0, 1'b1, OP_START, 1'b0, 0);
        idle(9);
        step(1'b0, 1'b1, OP_STOP, 1'b0, 0);
        check("stop_running0", 32'(running_a[0]), 0);
        rd('h0E); check("stop_hi", 32'(resdt_a), 'h00);
        rd('h0F); check("stop_lo", 32'(resdt_a), 'h0A);
        sweep("start_stop");

        // 256 increments on ch1: wrap vs saturate vs 16-bit.
        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b1, OP_START, 1'b0, 1);
        idle(255);
        step(1'b0, 1'b1, OP_SNAP, 1'b0, 1);
        rd('h11);
        check("wrap_snap", 32'(resdt_b), 'h00);
        check("sat_snap",  32'(resdt_c), 'hFF);
        check("w16_snap_lo", 32'(resdt_a), 'h00);
        rd('h10);
        check("w16_snap_hi", 32'(resdt_a), 'h01);
        check("wrap_ovf", 32'(ovf_b[1]), 1);
        check("sat_ovf",  32'(ovf_c[1]), 1);
        check("w16_ovf",  32'(ovf_a[1]), 0);
        sweep("overflow");
        idle(5);
        step(1'b0, 1'b1, OP_SNAP, 1'b0, 1);
        rd('h11);
        check("sat_hold", 32'(resdt_c), 'hFF);
        check("wrap_resume", 32'(resdt_b), 'h06);
        step(1'b0, 1'b1, OP_CLEAR, 1'b0, 1);
        check("clear_ovf_b", 32'(ovf_b[1]), 0);
        check("clear_ovf_c", 32'(ovf_c[1]), 0);
        sweep("clear_ovf");

        // CLEAR on running ch2 at count 5.
        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b1, OP_START, 1'b0, 2);
        idle(5);
        step(1'b0, 1'b1, OP_CLEAR, 1'b0, 2);
        step(1'b0, 1'b1, OP_SNAP, 1'b0, 2);
        rd('h13);
        check("clear_snap", 32'(resdt_a), 'h01);
        check("clear_ovf2", 32'(ovf_a[2]), 0);
        check("clear_run2", 32'(running_a[2]), 1);
        sweep("clear_run");

        // START all, STOP ch1 three edges later.
        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b1, OP_START, 1'b1, 0);
        idle(2);
        step(1'b0, 1'b1, OP_STOP, 1'b0, 1);
        rd('h16);
        check("status_a", 32'(resdt_a), 'hD0);
        check("status_b", 32'(resdt_b), 'hD0);
        rd('h14);
        check("status_c", 32'(resdt_c), 'h50);
        rd('h10); check("stop1_hi", 32'(resdt_a), 'h00);
        rd('h11); check("stop1_lo", 32'(resdt_a), 'h03);
        sweep("start_all");

        // Reset mid-run together with SNAP; nothing resumes afterwards.
        step(1'b1, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b1, OP_START, 1'b0, 3);
        idle(4);
        step(1'b1, 1'b1, OP_SNAP, 1'b0, 3);
        idle(3);
        step(1'b0, 1'b1, OP_SNAP, 1'b0, 3);
        check_all_zero("midrun_reset");
        sweep("midrun_reset");

        // Channel index beyond NCH is ignored by the 3-channel bank.
        step(1'b0, 1'b1, OP_START, 1'b0, 3);
        check("oob_running_c", 32'(running_c), 0);
        check("inb_running_a", 32'(running_a), 'h8);
        sweep("oob");

        // Randomized command stream.
        for (int n = 0; n < 1500; n++) begin
            bit rst, valid, all;
            int op, ch, a;
            rst   = ($urandom_range(199, 0) == 0);
            valid = ($urandom_range(4, 0) == 0);
            all   = ($urandom_range(7, 0) == 0);
            op    = int'($urandom_range(3, 0));
            ch    = int'($urandom_range(3, 0));
            step(rst, valid, op, all, ch);
            check_status("rand");
            a = ($urandom_range(15, 0) == 0) ? int'($urandom_range(255, 0))
                                             : int'($urandom_range('h18, 'h0C));
            rd(a);
            for (int k = 0; k < 3; k++) check("rand_resdt", got_rd(k), 32'(exp_rd(k, a)));
        end
        sweep("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
